// File: rtl/vga_frame_sequencer_if.sv
// Pixel-enable, update handshake and frame timing outputs of vga_frame_sequencer.
interface vga_frame_sequencer_if;
  logic       pixel_en;
  logic       update_done;
  logic       clear_overrun;
  logic [9:0] column_count;
  logic [9:0] row_count;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic       update_req;
  logic       overrun;
  logic [7:0] frame_count;

  modport master (
    output pixel_en, update_done, clear_overrun,
    input  column_count, row_count, hsync, vsync, active, update_req, overrun, frame_count
  );

  modport slave (
    input  pixel_en, update_done, clear_overrun,
    output column_count, row_count, hsync, vsync, active, update_req, overrun, frame_count
  );
endinterface

// File: rtl/vga_frame_sequencer.sv
// VGA frame timing master: pixel counters, registered syncs/active, and the
// vertical-blanking game-update handshake with sticky overrun detection.
module vga_frame_sequencer #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WIDTH  = 96,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2
) (
  input logic                   clock,
  input logic                   reset_n,
  vga_frame_sequencer_if.slave  bus
);

  localparam logic [9:0] COL_LAST     = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST     = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ROW_ACT_LAST = 10'(ACTIVE_ROWS - 1);
  localparam logic [9:0] COL_ACT      = 10'(ACTIVE_COLS);
  localparam logic [9:0] ROW_ACT      = 10'(ACTIVE_ROWS);
  localparam logic [9:0] HS_FIRST     = 10'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [9:0] HS_LAST      = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
  localparam logic [9:0] VS_FIRST     = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [9:0] VS_LAST      = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic       req_q, req_d;
  logic       ovr_q, ovr_d;
  logic [7:0] frame_q, frame_d;
  logic       line_end_s;
  logic       frame_start_s;
  logic       blank_start_s;
  logic       ovr_set_s;

  // Counters and sync/active decode; decoding the next counts keeps them cycle-aligned.
  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    frame_d       = frame_q;
    line_end_s    = (col_q == COL_LAST);
    frame_start_s = bus.pixel_en && line_end_s && (row_q == ROW_LAST);
    blank_start_s = bus.pixel_en && line_end_s && (row_q == ROW_ACT_LAST);
    if (bus.pixel_en) begin
      if (line_end_s) begin
        col_d = 10'd0;
        if (row_q == ROW_LAST) begin
          row_d = 10'd0;
        end else begin
          row_d = row_q + 10'd1;
        end
      end else begin
        col_d = col_q + 10'd1;
      end
      hsync_d  = !((col_d >= HS_FIRST) && (col_d <= HS_LAST));
      vsync_d  = !((row_d >= VS_FIRST) && (row_d <= VS_LAST));
      active_d = (col_d < COL_ACT) && (row_d < ROW_ACT);
      if (frame_start_s) begin
        frame_d = frame_q + 8'd1;
      end else begin
        frame_d = frame_q;
      end
    end else begin
      frame_d = frame_q;
    end
  end

  // Update handshake FSM; done on the frame-start edge still counts as in time.
  always_comb begin
    state_d   = state_q;
    ovr_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (blank_start_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (frame_start_s) begin
          state_d   = ST_IDLE;
          ovr_set_s = !bus.update_done;
        end else if (bus.update_done) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DONE: begin
        if (frame_start_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_d = (state_d == ST_REQ);
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (bus.clear_overrun) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      col_q    <= COL_LAST;
      row_q    <= ROW_LAST;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      active_q <= 1'b0;
      req_q    <= 1'b0;
      ovr_q    <= 1'b0;
      frame_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      req_q    <= req_d;
      ovr_q    <= ovr_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.column_count = col_q;
  assign bus.row_count    = row_q;
  assign bus.hsync        = hsync_q;
  assign bus.vsync        = vsync_q;
  assign bus.active       = active_q;
  assign bus.update_req   = req_q;
  assign bus.overrun      = ovr_q;
  assign bus.frame_count  = frame_q;

endmodule

// File: doc/vga_frame_sequencer.md
Name: vga_frame_sequencer

Overview:
- Master timing and scheduling controller for the 640x480@60Hz VGA pipeline.
- Generates pixel column/row counts and porch-correct, active-low Hsync/Vsync from a pixel-rate enable.
- Schedules the game-state update into vertical blanking with a req/done handshake, and flags updates that overrun into the next active frame.
- Sits upstream of the sync/porch and pixel-colour logic; its counts and syncs are the single timing source for the frame.

Parameters:
- TOTAL_COLS, 800, columns per line including blanking
- TOTAL_ROWS, 525, rows per frame including blanking
- ACTIVE_COLS, 640, visible columns
- ACTIVE_ROWS, 480, visible rows
- H_FRONT_PORCH, 16, columns between active video and Hsync pulse
- H_SYNC_WIDTH, 96, Hsync pulse width in columns
- V_FRONT_PORCH, 10, rows between active video and Vsync pulse
- V_SYNC_WIDTH, 2, Vsync pulse width in rows

Ports:
- clock  input  1  system clock; all logic on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- pixel_en  input  1  one-cycle pixel tick (e.g. 25 MHz rate); counters advance only when high
- update_done  input  1  game logic finished its frame update (level, sampled only in REQ)
- clear_overrun  input  1  synchronous clear of the overrun flag
- column_count  output  10  current column, 0..TOTAL_COLS-1
- row_count  output  10  current row, 0..TOTAL_ROWS-1
- hsync  output  1  active-low horizontal sync
- vsync  output  1  active-low vertical sync
- active  output  1  high when column < ACTIVE_COLS and row < ACTIVE_ROWS
- update_req  output  1  request to game logic to perform its per-frame update
- overrun  output  1  sticky: an update was still pending when the next frame started
- frame_count  output  8  frames started since reset, wraps 255->0

Behaviour:
- Reset (async assert, sync release)
  - column_count=799, row_count=524, hsync=1, vsync=1, active=0.
  - update_req=0, overrun=0, frame_count=0, FSM=IDLE.
  - Reset mid-frame aborts any request immediately.
- Counters, on clock edge with pixel_en=1
  - Column increments; at TOTAL_COLS-1 it wraps to 0 and row increments.
  - Row wraps from TOTAL_ROWS-1 to 0.
  - pixel_en=0: every register holds.
- Sync/active outputs
  - All registered and computed from the next counter values, so hsync, vsync and active are aligned with column_count/row_count in the same cycle (zero relative latency).
  - hsync=0 iff 656 <= column <= 751 (ACTIVE_COLS+H_FRONT_PORCH .. +H_SYNC_WIDTH-1).
  - vsync=0 iff 490 <= row <= 491.
- Frame start event: counters move (799,524)->(0,0).
  - frame_count increments (first tick after reset gives 1).
- Blank start event: counters move (799,479)->(0,480).
- Update FSM: IDLE, REQ, DONE.
  - IDLE->REQ on blank start; update_req=1 from that edge.
  - REQ->DONE on any edge with update_done=1; update_req=0 from that edge. update_done does not need pixel_en.
  - REQ->IDLE on frame start while update_done=0; overrun set, update_req=0.
  - DONE->IDLE on frame start.
  - update_done in IDLE or DONE is ignored.
- Simultaneous events
  - update_done=1 on the frame-start edge counts as done: no overrun, FSM->IDLE.
  - Set and clear_overrun on the same edge: set wins.
  - clear_overrun alone clears on the next edge.
- Width rules
  - Counters are 10-bit unsigned; parameters must satisfy TOTAL_COLS, TOTAL_ROWS <= 1024.
  - frame_count is a modulo-256 counter.

Test Plan:
- Reset release, pixel_en tied high for 1 cycle -> column=0, row=0, active=1, hsync=1, vsync=1, frame_count=1.
- Run one full line -> hsync low exactly for columns 656..751 (96 ticks); active low for columns 640..799; row increments after column 799.
- Run to row 480 col 0 -> update_req rises on that edge. Assert update_done for 1 cycle at row 500 -> update_req falls next edge; no overrun at the following frame start.
- Never assert update_done -> on (799,524)->(0,0), update_req falls and overrun=1. overrun stays 1 across the next frame until clear_overrun is pulsed; set and clear on the same edge leaves overrun=1.
- Toggle pixel_en at 1-in-4 with update_done asserted exactly on the frame-start edge -> counters advance only on enabled ticks; overrun stays 0; frame_count counts 255->0.
- Assert reset_n low at row 485 while REQ -> all outputs return to reset values asynchronously. After release, the first tick gives (0,0) and no overrun.
